// File: rtl/serial_frame_deserializer.sv
// Serial-to-parallel frame receiver: hunts for a sync word, confirms
// frame lock, then delivers payload words with a one-cycle strobe.
module serial_frame_deserializer #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD    = 16'hA5C3,
  parameter int               DATA_WORDS   = 7,
  parameter int               LOCK_COUNT   = 2,
  parameter int               UNLOCK_COUNT = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SERIAL_IN,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             PAR_VALID,
  output logic             PAR_FIRST,
  output logic             LOCKED,
  output logic             SYNC_ERR
);

  localparam int BW = $clog2(WIDTH);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(DATA_WORDS + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CONFIRM,
    ST_LOCKED
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [FW-1:0]    fill, fill_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [SW-1:0]    slot, slot_n, slot_adv;
  logic [GW-1:0]    good, good_n, good_inc;
  logic [UW-1:0]    bad, bad_n, bad_inc;
  logic [WIDTH-1:0] out_n;
  logic             valid_n;
  logic             first_n;
  logic             err_n;
  logic             full;
  logic             sync_ok;
  logic             done;

  always_comb begin
    sr_n     = {SERIAL_IN, sr[WIDTH-1:1]};
    fill_n   = (fill == FW'(WIDTH)) ? fill : fill + 1'b1;
    full     = (fill_n == FW'(WIDTH));
    sync_ok  = (sr_n == SYNC_WORD);
    done     = (bit_cnt == BW'(WIDTH - 1));
    slot_adv = (slot == SW'(DATA_WORDS)) ? '0 : slot + 1'b1;
    good_inc = (good == GW'(LOCK_COUNT)) ? good : good + 1'b1;
    bad_inc  = (bad == UW'(UNLOCK_COUNT)) ? bad : bad + 1'b1;
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = done ? '0 : bit_cnt + 1'b1;
    slot_n    = slot;
    good_n    = good;
    bad_n     = bad;
    out_n     = PAR_OUT;
    valid_n   = 1'b0;
    first_n   = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      ST_HUNT: begin
        if (full && sync_ok) begin
          state_n   = ST_CONFIRM;
          bit_cnt_n = '0;
          slot_n    = SW'(1);
          good_n    = GW'(1);
        end
      end
      ST_CONFIRM: begin
        if (done) begin
          slot_n = slot_adv;
          if (slot == '0) begin
            if (sync_ok) begin
              good_n = good_inc;
              if (int'(good) + 1 >= LOCK_COUNT) begin
                state_n = ST_LOCKED;
                bad_n   = '0;
              end
            end else begin
              err_n   = 1'b1;
              state_n = ST_HUNT;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (done) begin
          slot_n = slot_adv;
          if (slot == '0) begin
            if (sync_ok) begin
              bad_n = '0;
            end else begin
              err_n = 1'b1;
              bad_n = bad_inc;
              if (int'(bad) + 1 >= UNLOCK_COUNT) begin
                state_n = ST_HUNT;
              end
            end
          end else begin
            out_n   = sr_n;
            valid_n = 1'b1;
            first_n = (slot == SW'(1));
          end
        end
      end
      default: state_n = ST_HUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_HUNT;
      sr        <= '0;
      fill      <= '0;
      bit_cnt   <= '0;
      slot      <= '0;
      good      <= '0;
      bad       <= '0;
      PAR_OUT   <= '0;
      PAR_VALID <= 1'b0;
      PAR_FIRST <= 1'b0;
      LOCKED    <= 1'b0;
      SYNC_ERR  <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      fill      <= fill_n;
      bit_cnt   <= bit_cnt_n;
      slot      <= slot_n;
      good      <= good_n;
      bad       <= bad_n;
      PAR_OUT   <= out_n;
      PAR_VALID <= valid_n;
      PAR_FIRST <= first_n;
      LOCKED    <= (state_n == ST_LOCKED);
      SYNC_ERR  <= err_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Scoreboard bench for serial_frame_deserializer: a bit-history reference
// model predicts every cycle's outputs and the delivered payload words.
module tb_serial_frame_deserializer;

  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam int W  = 16;
  localparam int DW = 7;
  localparam int M_HUNT = 0;
  localparam int M_CONF = 1;
  localparam int M_LOCK = 2;

  logic        CLK;
  logic        RESET;
  logic        SERIAL_IN;
  logic [15:0] PAR_OUT;
  logic        PAR_VALID;
  logic        PAR_FIRST;
  logic        LOCKED;
  logic        SYNC_ERR;

  serial_frame_deserializer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SERIAL_IN (SERIAL_IN),
    .PAR_OUT   (PAR_OUT),
    .PAR_VALID (PAR_VALID),
    .PAR_FIRST (PAR_FIRST),
    .LOCKED    (LOCKED),
    .SYNC_ERR  (SYNC_ERR)
  );

  typedef struct packed {
    logic        valid;
    logic        first;
    logic [15:0] out;
    logic        locked;
    logic        err;
  } cyc_t;

  typedef struct packed {
    logic [15:0] w;
    logic        first;
  } word_t;

  cyc_t  cyc_q[$];
  word_t data_q[$];
  int    checks   = 0;
  int    failures = 0;

  bit          hist[$];
  int          nbits;
  int          align;
  int          goods;
  int          bads;
  int          mode;
  logic [15:0] exp_out;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_step(input bit r, input bit b);
    cyc_t        e;
    logic [15:0] w;
    int          k;
    e = '0;
    if (r) begin
      hist.delete();
      nbits   = 0;
      mode    = M_HUNT;
      exp_out = '0;
    end else begin
      hist.push_back(b);
      nbits++;
      if (hist.size() > W) void'(hist.pop_front());
      w = '0;
      if (hist.size() == W)
        for (int i = 0; i < W; i++) w[i] = hist[i];
      if (mode == M_HUNT) begin
        if (nbits >= W && w == SYNC) begin
          mode  = M_CONF;
          align = nbits;
          goods = 1;
        end
      end else if ((nbits - align) % W == 0) begin
        k = ((nbits - align) / W) % (DW + 1);
        if (k == 0) begin
          if (w == SYNC) begin
            if (mode == M_CONF) begin
              goods++;
              if (goods >= 2) begin
                mode = M_LOCK;
                bads = 0;
              end
            end else begin
              bads = 0;
            end
          end else begin
            e.err = 1'b1;
            if (mode == M_CONF) begin
              mode = M_HUNT;
            end else begin
              bads++;
              if (bads >= 2) mode = M_HUNT;
            end
          end
        end else if (mode == M_LOCK) begin
          e.valid = 1'b1;
          e.first = (k == 1);
          exp_out = w;
          data_q.push_back('{w: w, first: (k == 1)});
        end
      end
    end
    e.out    = exp_out;
    e.locked = (mode == M_LOCK);
    cyc_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit b);
    @(negedge CLK);
    RESET     = r;
    SERIAL_IN = b;
    model_step(r, b);
  endtask

  task automatic send_word(input logic [15:0] w, input int skip, input int rst_at);
    for (int i = 0; i < W; i++) begin
      if (i == rst_at) drive(1'b1, 1'b0);
      if (i != skip) drive(1'b0, w[i]);
    end
  endtask

  task automatic send_frame(input logic [15:0] sync, input bit counting,
                            input int slip_word, input int rst_word);
    logic [15:0] p;
    send_word(sync, -1, -1);
    for (int k = 1; k <= DW; k++) begin
      p = counting ? 16'(k) : 16'($urandom);
      send_word(p, (k == slip_word) ? 9 : -1, (k == rst_word) ? 5 : -1);
    end
  endtask

  initial begin
    cyc_t  e;
    word_t d;
    forever begin
      @(posedge CLK);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        checks++;
        if ({PAR_VALID, PAR_FIRST, PAR_OUT, LOCKED, SYNC_ERR} !== e) begin
          failures++;
          $display("FAIL cycle_outputs t=%0t got v=%b f=%b out=%h lk=%b err=%b want v=%b f=%b out=%h lk=%b err=%b",
                   $time, PAR_VALID, PAR_FIRST, PAR_OUT, LOCKED, SYNC_ERR,
                   e.valid, e.first, e.out, e.locked, e.err);
        end
        if (PAR_VALID === 1'b1) begin
          checks++;
          if (data_q.size() == 0) begin
            failures++;
            $display("FAIL payload_word t=%0t got %h first=%b want no word", $time, PAR_OUT, PAR_FIRST);
          end else begin
            d = data_q.pop_front();
            if (PAR_OUT !== d.w || PAR_FIRST !== d.first) begin
              failures++;
              $display("FAIL payload_word t=%0t got %h first=%b want %h first=%b",
                       $time, PAR_OUT, PAR_FIRST, d.w, d.first);
            end
          end
        end
      end
    end
  end

  initial begin
    RESET     = 1'b1;
    SERIAL_IN = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);

    for (int f = 0; f < 4; f++) send_frame(SYNC, 1'b1, -1, -1);

    drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'($urandom));
    for (int f = 0; f < 3; f++) send_frame(SYNC, 1'b0, -1, -1);

    drive(1'b1, 1'b0);
    send_word(16'h1234, -1, -1);
    send_word(SYNC, -1, -1);
    send_word(16'h0F0F, -1, -1);
    for (int f = 0; f < 4; f++) send_frame(SYNC, 1'b1, -1, -1);

    send_frame(SYNC ^ 16'h0100, 1'b0, -1, -1);
    for (int f = 0; f < 2; f++) send_frame(SYNC, 1'b0, -1, -1);
    send_frame(SYNC ^ 16'h0001, 1'b1, -1, -1);
    send_frame(SYNC ^ 16'h8000, 1'b1, -1, -1);
    for (int f = 0; f < 3; f++) send_frame(SYNC, 1'b1, -1, -1);

    send_frame(SYNC, 1'b1, -1, 4);
    for (int f = 0; f < 4; f++) send_frame(SYNC, 1'b1, -1, -1);

    send_frame(SYNC, 1'b0, 3, -1);
    for (int f = 0; f < 5; f++) send_frame(SYNC, 1'b0, -1, -1);

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    @(posedge CLK);
    #3;
    checks++;
    if (cyc_q.size() != 0) begin
      failures++;
      $display("FAIL cycle_queue_drain got %0d left want 0", cyc_q.size());
    end
    checks++;
    if (data_q.size() != 0) begin
      failures++;
      $display("FAIL payload_drain got %0d words undelivered want 0", data_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
